// File: rtl/pc_next_sel.sv
// Next-PC generator: owns the fetch PC, arbitrates prioritised redirects and
// parks a redirect that arrives during a fetch stall. Optional PC_ALIGN_CHECK_EN.
module pc_next_sel #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NSRC      = 5,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] ILLOP_VEC = WIDTH'(32'h0000_4180)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         redir_valid,
  input  logic [NSRC*WIDTH-1:0]   redir_target,
  input  logic                    fetch_ready,
  output logic [WIDTH-1:0]        pc,
  output logic                    pc_valid,
  output logic [NSRC-1:0]         redir_taken,
  output logic                    pending,
  output logic                    misalign_err
);

  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic [NSRC-1:0]   taken_q, taken_d;
  logic              pending_q, pending_d;
  logic              misalign_q, misalign_d;
  logic [WIDTH-1:0]  buf_tgt_q, buf_tgt_d;
  logic [IDXW-1:0]   buf_idx_q, buf_idx_d;

  logic              win_vld;
  logic [IDXW-1:0]   win_idx;
  logic [WIDTH-1:0]  win_tgt;
  logic              upgrade;
  logic [WIDTH-1:0]  ld_tgt;
  logic [IDXW-1:0]   ld_idx;
  logic              ld_bad;
  logic [WIDTH-1:0]  ld_pc;
  logic [NSRC-1:0]   ld_onehot;

  // Lowest-index requester wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_tgt = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(i);
        win_tgt = redir_target[i*WIDTH +: WIDTH];
      end
    end
  end

  // A live request only beats the parked one if it is strictly higher priority.
  assign upgrade = win_vld && (win_idx < buf_idx_q);

  // Target that would be loaded this cycle, after optional alignment fixup.
  always_comb begin
    ld_tgt = buf_tgt_q;
    ld_idx = buf_idx_q;
    if ((state_q == ST_RUN) || upgrade) begin
      ld_tgt = win_tgt;
      ld_idx = win_idx;
    end
    ld_bad    = ALIGN_CHECK && (ld_tgt[1:0] != 2'b00);
    ld_pc     = ld_bad ? ILLOP_VEC : ld_tgt;
    ld_onehot = NSRC'(1) << ld_idx;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!fetch_ready && win_vld) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fetch_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    taken_d    = '0;
    pending_d  = pending_q;
    misalign_d = 1'b0;
    buf_tgt_d  = buf_tgt_q;
    buf_idx_d  = buf_idx_q;
    unique case (state_q)
      ST_BOOT: begin
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (fetch_ready) begin
          if (win_vld) begin
            pc_d       = ld_pc;
            taken_d    = ld_onehot;
            misalign_d = ld_bad;
          end else begin
            pc_d = pc_q + WIDTH'(4);
          end
        end else if (win_vld) begin
          buf_tgt_d = win_tgt;
          buf_idx_d = win_idx;
          pending_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (fetch_ready) begin
          pc_d       = ld_pc;
          taken_d    = ld_onehot;
          misalign_d = ld_bad;
          pending_d  = 1'b0;
        end else if (upgrade) begin
          buf_tgt_d = win_tgt;
          buf_idx_d = win_idx;
        end
      end
      default: begin
        pc_valid_d = 1'b0;
        pending_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      taken_q    <= '0;
      pending_q  <= 1'b0;
      misalign_q <= 1'b0;
      buf_tgt_q  <= '0;
      buf_idx_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      taken_q    <= taken_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_idx_q  <= buf_idx_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign redir_taken  = taken_q;
  assign pending      = pending_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_next_sel.sv
// Self-checking bench for pc_next_sel: per-cycle comparison against a
// transaction-level model plus literal expectations from the test plan.
module tb_pc_next_sel;

  localparam int W = 32;
  localparam int N = 5;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    redir_valid;
  logic [N*W-1:0]  redir_target;
  logic            fetch_ready;
  logic [W-1:0]    pc;
  logic            pc_valid;
  logic [N-1:0]    redir_taken;
  logic            pending;
  logic            misalign_err;

  int checks   = 0;
  int failures = 0;

  pc_next_sel dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .fetch_ready  (fetch_ready),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .redir_taken  (redir_taken),
    .pending      (pending),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: boot flag, parked request (target, source), and the visible outputs.
  bit          m_boot, m_hold, m_valid, m_mis;
  logic [31:0] m_pc, m_buf;
  int          m_bidx;
  logic [4:0]  m_taken;

  task automatic m_load(input logic [31:0] t, input int idx);
    if (ALN && (t % 4 != 0)) begin
      m_pc  = 32'h0000_4180;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
    m_taken = 5'(1 << idx);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_hold = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
      m_pc = 32'h0000_3000; m_buf = '0; m_bidx = 0; m_taken = '0;
    end else begin
      int w;
      w = -1;
      for (int i = 0; i < N; i++) if (redir_valid[i] && w < 0) w = i;
      m_taken = '0;
      m_mis   = 1'b0;
      if (m_boot) begin
        m_boot  = 1'b0;
        m_valid = 1'b1;
      end else if (!m_hold) begin
        if (fetch_ready) begin
          if (w >= 0) m_load(redir_target[w*W +: W], w);
          else m_pc = m_pc + 32'd4;
        end else if (w >= 0) begin
          m_hold = 1'b1;
          m_buf  = redir_target[w*W +: W];
          m_bidx = w;
        end
      end else begin
        if (w >= 0 && w < m_bidx) begin
          m_buf  = redir_target[w*W +: W];
          m_bidx = w;
        end
        if (fetch_ready) begin
          m_load(m_buf, m_bidx);
          m_hold = 1'b0;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("cmp_pc", pc, m_pc);
    chk("cmp_pc_valid", 32'(pc_valid), 32'(m_valid));
    chk("cmp_taken", 32'(redir_taken), 32'(m_taken));
    chk("cmp_pending", 32'(pending), 32'(m_hold));
    chk("cmp_misalign", 32'(misalign_err), 32'(m_mis));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_tgt(input int idx, input logic [31:0] t);
    redir_target[idx*W +: W] = t;
  endtask

  // Directed sequence for the model sweep: targets are base + 16*source.
  logic        tv_fr  [12] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1};
  logic [4:0]  tv_vld [12] = '{5'b00100, 5'b00100, 5'b01000, 5'b00000, 5'b00000, 5'b01000,
                               5'b10000, 5'b00001, 5'b00000, 5'b11111, 5'b10000, 5'b00000};
  logic [31:0] tv_base[12] = '{32'h3700, 32'h3780, 32'h3800, 32'h3880, 32'h3900, 32'h3983,
                               32'h3A03, 32'h3B00, 32'h3B80, 32'h3C00, 32'h3C02, 32'h3D00};

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; redir_valid = '0; redir_target = '0;
    step(); step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    step();
    chk("boot_pc", pc, 32'h3000);
    chk("boot_pc_valid", 32'(pc_valid), 32'd1);
    step();
    chk("seq_pc_3004", pc, 32'h3004);
    step();
    chk("seq_pc_3008", pc, 32'h3008);

    redir_valid = 5'b10100; set_tgt(2, 32'h3100); set_tgt(4, 32'h3200);
    step();
    chk("prio_pc", pc, 32'h3100);
    chk("prio_taken", 32'(redir_taken), 32'b00100);
    redir_valid = '0;
    step();
    chk("prio_taken_pulse", 32'(redir_taken), 32'd0);
    chk("after_prio_pc", pc, 32'h3104);

    fetch_ready = 1'b0; redir_valid = 5'b01000; set_tgt(3, 32'h3300);
    step();
    chk("stall_pending", 32'(pending), 32'd1);
    chk("stall_pc", pc, 32'h3104);
    redir_valid = 5'b00010; set_tgt(1, 32'h3400);
    step();
    redir_valid = 5'b10000; set_tgt(4, 32'h3500);
    step();
    chk("hold_pc", pc, 32'h3104);
    redir_valid = '0; fetch_ready = 1'b1;
    step();
    chk("upg_pc", pc, 32'h3400);
    chk("upg_taken", 32'(redir_taken), 32'b00010);
    chk("upg_pending", 32'(pending), 32'd0);
    step();
    chk("post_upg_pc", pc, 32'h3404);

    fetch_ready = 1'b0; redir_valid = 5'b00001; set_tgt(0, 32'h3600);
    step();
    chk("mid_hold_pending", 32'(pending), 32'd1);
    redir_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_pc_valid", 32'(pc_valid), 32'd0);
    chk("async_taken", 32'(redir_taken), 32'd0);
    chk("async_pc", pc, 32'h3000);
    fetch_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reboot_pc", pc, 32'h3000);
    step();
    chk("no_stale_pc", pc, 32'h3004);

    redir_valid = 5'b00001; set_tgt(0, 32'hFFFF_FFFC);
    step();
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    redir_valid = '0;
    step();
    chk("wrap_pc", pc, 32'h0000_0000);

    redir_valid = 5'b00100; set_tgt(2, 32'h3102);
    step();
    chk("align_pc", pc, ALN ? 32'h4180 : 32'h3102);
    chk("align_err", 32'(misalign_err), 32'(ALN));
    chk("align_taken", 32'(redir_taken), 32'b00100);
    redir_valid = '0;
    step();
    chk("align_err_pulse", 32'(misalign_err), 32'd0);
    chk("align_next_pc", pc, ALN ? 32'h4184 : 32'h3106);

    for (int k = 0; k < 12; k++) begin
      fetch_ready = tv_fr[k];
      redir_valid = tv_vld[k];
      for (int s = 0; s < N; s++) set_tgt(s, tv_base[k] + 32'(16 * s));
      step();
    end
    redir_valid = '0; fetch_ready = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_next_sel.md
# pc_next_sel

Parametrised next-PC generator for the fetch stage: owns the PC register, arbitrates NSRC prioritised redirect requests, and advances by 4 otherwise. A one-entry redirect hold buffer keeps a redirect that arrives while fetch is stalled, so no control transfer is lost. It replaces the purely combinational PC-source mux and sits between the hazard/branch/exception logic and instruction fetch.

## Interface
- WIDTH, 32: PC width in bits (≥ 3).
- NSRC, 5: number of redirect sources; index 0 is highest priority.
- RESET_PC, 32'h0000_3000: PC value after reset.
- ILLOP_VEC, 32'h0000_4180: vector used for misaligned targets (see Configuration).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redir_valid  in  NSRC  per-source redirect request, level.
- redir_target  in  NSRC*WIDTH  flattened targets; source i occupies bits [i*WIDTH +: WIDTH].
- fetch_ready  in  1  fetch accepts the current PC this cycle.
- pc  out  WIDTH  current fetch PC, registered.
- pc_valid  out  1  pc is presentable to fetch.
- redir_taken  out  NSRC  one-hot, registered; marks the cycle pc first shows a redirect target.
- pending  out  1  hold buffer occupied.
- misalign_err  out  1  registered pulse; macro-dependent.

## Operation
- States: BOOT, RUN, HOLD. Hold buffer: target (WIDTH), source index (clog2 NSRC).
- Reset (async, any time, including mid-HOLD): state=BOOT, pc=RESET_PC, pc_valid=0, redir_taken=0, pending=0, misalign_err=0, buffer cleared.
- BOOT: one cycle. All inputs are ignored. Next state is RUN with pc_valid=1 and pc unchanged (RESET_PC).
- Selection: win = lowest index i with redir_valid[i]=1.
- RUN, fetch_ready=1:
  - With win: pc<=target[win]; redir_taken<=onehot(win).
  - Without win: pc<=pc+4 (mod 2^WIDTH); redir_taken<=0.
- RUN, fetch_ready=0:
  - With win: buffer<=(target[win], win); pending<=1; go HOLD; pc holds.
  - Without win: pc holds.
- HOLD, fetch_ready=0: if win exists with win < held index, the buffer is replaced by win. Equal or lower priority requests are dropped. pc holds.
- HOLD, fetch_ready=1:
  - If win < held index: load target[win].
  - Otherwise: load the buffered target.
  - In both cases redir_taken<=onehot(used index), pending<=0, go RUN.
- A redirect is consumed once. Sources must deassert redir_valid after redir_taken; a still-asserted valid counts as a new request.
- pc+4 wrap: all-ones-minus-3 advances to 0. No error is flagged.

## Timing
- Redirect latency: the request is sampled on edge N with fetch_ready=1, and pc=target plus the redir_taken pulse are visible after edge N.
- Stalled redirect: pc changes on the first edge where fetch_ready=1.
- pending rises on the edge after the stalled request and falls on the consuming edge.
- redir_taken and misalign_err are high for exactly one cycle.
- pc_valid is 0 only in BOOT and rises after the first edge following reset release.
- No combinational path from inputs to outputs.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A selected target (direct or buffered) with bits [1:0] != 0 is replaced by ILLOP_VEC at load.
  - misalign_err pulses in the same cycle pc shows ILLOP_VEC.
  - redir_taken still reports the originating source.
- Undefined: targets load verbatim and misalign_err is tied 0.

## Test plan
- Reset:
  - Release rst_n → pc=0x3000, pc_valid=0 for one cycle, then pc_valid=1.
  - With fetch_ready=1 and no redirects → pc 0x3004, 0x3008 on successive edges.
- Priority: redir_valid=5'b10100 with targets src2=0x3100 and src4=0x3200, fetch_ready=1 → pc=0x3100, redir_taken=5'b00100.
- Stall with upgrade:
  - fetch_ready=0; src3 requests 0x3300 → pending=1.
  - Then src1 requests 0x3400, then src4 requests 0x3500 (dropped).
  - fetch_ready=1 → pc=0x3400, redir_taken=5'b00010, pending=0.
- Reset mid-HOLD: assert rst_n=0 while pending=1 → pending, pc_valid, and redir_taken clear immediately; pc=0x3000; the buffered target is never loaded.
- Wrap: force pc=0xFFFF_FFFC via a redirect, then fetch_ready=1 with no redirect → pc=0x0000_0000.
- Alignment (macro on): redirect to 0x3102 → pc=0x4180, misalign_err=1 for one cycle. With the macro off → pc=0x3102 and misalign_err=0.
